// File: rtl/matrix_pkg.sv
// Shared constants and FSM state type for the 3x3 matrix input loader.
package matrix_pkg;
  localparam int MAT_DIM    = 3;
  localparam int MAT_ELEMS  = MAT_DIM * MAT_DIM;
  localparam int ELEM_W     = 8;
  localparam int LOAD_ELEMS = 2 * MAT_ELEMS;
  localparam int IDX_W      = $clog2(LOAD_ELEMS + 1);

  typedef enum logic {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_t;
endpackage

// File: rtl/btn_debounce.sv
// Synchronizes a raw push-button, debounces its level and emits a single
// pulse on each accepted press (0->1); releases produce nothing.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_reg;
  logic             level_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             press_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg  <= '0;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
      press_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], raw};
      press_reg <= 1'b0;
      if (sync_reg[1] != level_reg) begin
        // Nth consecutive differing cycle commits the new level.
        if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level_reg <= sync_reg[1];
          cnt_reg   <= '0;
          press_reg <= sync_reg[1];
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign press = press_reg;
endmodule

// File: rtl/matrix_input_loader.sv
// Captures 18 switch values on debounced button presses (A then B, row-major)
// and streams them out over a valid/ready interface.
module matrix_input_loader
  import matrix_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn,
  input  logic [ELEM_W-1:0] switches,
  output logic              elem_valid,
  input  logic              elem_ready,
  output logic [ELEM_W-1:0] elem_data,
  output logic              elem_last,
  output logic [IDX_W-1:0]  entry_count,
  output logic              busy
);
  logic              press;
  logic [ELEM_W-1:0] sw_meta_reg;
  logic [ELEM_W-1:0] sw_sync_reg;
  logic [ELEM_W-1:0] buf_reg [LOAD_ELEMS];
  logic [LOAD_ELEMS-1:0] wr_en;

  state_t            state_reg;
  logic [IDX_W-1:0]  entry_count_reg;
  logic [IDX_W-1:0]  rd_idx_reg;
  logic [IDX_W-1:0]  rd_idx_next;
  logic              elem_valid_reg;
  logic [ELEM_W-1:0] elem_data_reg;
  logic              elem_last_reg;
  logic              busy_reg;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn),
    .press (press)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      sw_meta_reg <= switches;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LOAD_ELEMS; gi++) begin : g_wr
      assign wr_en[gi] = (state_reg == COLLECT) && press &&
                         (entry_count_reg == IDX_W'(gi));
    end
  endgenerate

  // Buffer contents survive reset; only the fill index is cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LOAD_ELEMS; i++) begin
      if (wr_en[i]) buf_reg[i] <= sw_sync_reg;
    end
  end

  assign rd_idx_next = rd_idx_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= COLLECT;
      entry_count_reg <= '0;
      rd_idx_reg      <= '0;
      elem_valid_reg  <= 1'b0;
      elem_data_reg   <= '0;
      elem_last_reg   <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (press) begin
            entry_count_reg <= entry_count_reg + 1'b1;
            if (entry_count_reg == IDX_W'(LOAD_ELEMS - 1)) begin
              state_reg      <= SEND;
              rd_idx_reg     <= '0;
              elem_valid_reg <= 1'b1;
              elem_data_reg  <= buf_reg[0];
              elem_last_reg  <= (LOAD_ELEMS == 1);
              busy_reg       <= 1'b1;
            end
          end
        end
        SEND: begin
          // Outputs hold until the consumer takes the current element.
          if (elem_ready) begin
            if (rd_idx_reg == IDX_W'(LOAD_ELEMS - 1)) begin
              state_reg       <= COLLECT;
              entry_count_reg <= '0;
              rd_idx_reg      <= '0;
              elem_valid_reg  <= 1'b0;
              elem_data_reg   <= '0;
              elem_last_reg   <= 1'b0;
              busy_reg        <= 1'b0;
            end else begin
              rd_idx_reg    <= rd_idx_next;
              elem_data_reg <= buf_reg[rd_idx_next];
              elem_last_reg <= (rd_idx_next == IDX_W'(LOAD_ELEMS - 1));
            end
          end
        end
        default: state_reg <= COLLECT;
      endcase
    end
  end

  assign elem_valid  = elem_valid_reg;
  assign elem_data   = elem_data_reg;
  assign elem_last   = elem_last_reg;
  assign entry_count = entry_count_reg;
  assign busy        = busy_reg;
endmodule

// File: tb/tb_matrix_input_loader.sv
// Directed bench for matrix_input_loader with a short debounce window.
module tb_matrix_input_loader;
  import matrix_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic [7:0] switches = 8'h00;
  logic       elem_ready = 1'b0;
  logic       elem_valid;
  logic [7:0] elem_data;
  logic       elem_last;
  logic [4:0] entry_count;
  logic       busy;

  int passed = 0;
  int total  = 0;
  int presses = 0;
  int p0;
  logic [7:0] exp_data [18];

  matrix_input_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .switches    (switches),
    .elem_valid  (elem_valid),
    .elem_ready  (elem_ready),
    .elem_data   (elem_data),
    .elem_last   (elem_last),
    .entry_count (entry_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut.u_debounce.press === 1'b1) presses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic press_btn(input logic [7:0] v, input int hold);
    @(negedge clk);
    switches = v;
    btn = 1'b1;
    repeat (hold) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
    $display("press value=%02h entry_count=%0d", v, entry_count);
  endtask

  // stall: ready follows 1,0,0,1 repeating; poke: press button mid-stream
  task automatic stream(input bit stall, input bit poke);
    int k = 0;
    int c = 0;
    int first_c = -1;
    int last_c = -1;
    bit was_stall = 1'b0;
    logic [7:0] held = 8'h00;
    while (k < 18 && c < 200) begin
      elem_ready = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      if (poke) btn = (c >= 2 && c < 14);
      if (was_stall) check("stall_hold", {24'd0, elem_data}, {24'd0, held});
      if (elem_valid && elem_ready) begin
        $display("xfer k=%0d data=%02h last=%0b cycle=%0d", k, elem_data, elem_last, c);
        check("xfer_data", {24'd0, elem_data}, {24'd0, exp_data[k]});
        check("xfer_last", {31'd0, elem_last}, {31'd0, (k == 17)});
        check("xfer_busy", {31'd0, busy}, 32'd1);
        check("xfer_count", {27'd0, entry_count}, 32'd18);
        if (first_c < 0) first_c = c;
        last_c = c;
        k++;
      end
      was_stall = elem_valid && !elem_ready;
      held = elem_data;
      c++;
      @(negedge clk);
    end
    btn = 1'b0;
    elem_ready = 1'b0;
    check("stream_transfers", k, 18);
    if (!stall) check("stream_span", last_c - first_c, 17);
    check("post_valid", {31'd0, elem_valid}, 32'd0);
    check("post_busy", {31'd0, busy}, 32'd0);
    check("post_count", {27'd0, entry_count}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, elem_valid}, 32'd0);
    check("rst_data", {24'd0, elem_data}, 32'd0);
    check("rst_last", {31'd0, elem_last}, 32'd0);
    check("rst_count", {27'd0, entry_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Glitch shorter than the debounce window, with ready high in COLLECT
    elem_ready = 1'b1;
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
    $display("glitch presses=%0d entry_count=%0d", presses, entry_count);
    check("glitch_presses", presses, 0);
    check("glitch_count", {27'd0, entry_count}, 32'd0);
    check("collect_valid", {31'd0, elem_valid}, 32'd0);
    elem_ready = 1'b0;

    // Long hold gives exactly one press
    press_btn(8'd1, 100);
    check("hold_presses", presses, 1);
    check("hold_count", {27'd0, entry_count}, 32'd1);
    for (int k = 2; k <= 18; k++) begin
      press_btn(8'(k), 10);
      check("fill_count", {27'd0, entry_count}, k);
    end
    for (int k = 0; k < 18; k++) exp_data[k] = 8'(k + 1);
    check("send_valid", {31'd0, elem_valid}, 32'd1);
    check("send_busy", {31'd0, busy}, 32'd1);
    check("send_first", {24'd0, elem_data}, 32'd1);
    stream(1'b0, 1'b0);

    // Second set: stalled stream with a press during SEND
    for (int k = 1; k <= 18; k++) begin
      press_btn(8'(k), 10);
      check("fill2_count", {27'd0, entry_count}, k);
    end
    p0 = presses;
    stream(1'b1, 1'b1);
    check("send_press_seen", presses, p0 + 1);
    repeat (12) @(negedge clk);
    check("after_send_count", {27'd0, entry_count}, 32'd0);
    press_btn(8'h55, 10);
    check("restart_count", {27'd0, entry_count}, 32'd1);
    check("restart_buf0", {24'd0, dut.buf_reg[0]}, 32'h55);

    // Partial fill abandoned by reset
    for (int k = 1; k < 10; k++) press_btn(8'hA0 + 8'(k), 10);
    check("partial_count", {27'd0, entry_count}, 32'd10);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst2_count", {27'd0, entry_count}, 32'd0);
    check("rst2_valid", {31'd0, elem_valid}, 32'd0);
    for (int k = 0; k < 18; k++) begin
      press_btn(8'hF0 + 8'(k), 10);
      exp_data[k] = 8'hF0 + 8'(k);
    end
    check("new_first", {24'd0, elem_data}, 32'hF0);
    stream(1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
